// File: rtl/arbitro_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arbitro_pkg : shared constants, states and helpers for WRR arb  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package arbitro_pkg;

   localparam int NUM_Q  = 4;
   localparam int DEST_W = 2;
   localparam int CRED_W = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   function automatic logic [NUM_Q-1:0] onehot4(input logic [DEST_W-1:0] idx);
      logic [NUM_Q-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // A zero quantum would starve the queue, so it is promoted to 1.
   function automatic logic [CRED_W-1:0] quantum(input int w);
      if (w < 1)
         return CRED_W'(1);
      else if (w > 15)
         return CRED_W'(15);
      else
         return CRED_W'(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_wrr_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arbitro_wrr_if : input/output FIFO bank signals of the WRR arb  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface arbitro_wrr_if
   import arbitro_pkg::*;
#(
   parameter int DATA_W = 10
);
   logic [NUM_Q-1:0]        empty_P;
   logic [NUM_Q-1:0]        pop_P;
   logic [NUM_Q*DATA_W-1:0] data_P;
   logic [NUM_Q-1:0]        almost_full_F;
   logic [NUM_Q-1:0]        push_F;
   logic [DATA_W-1:0]       data_F;
   logic [DEST_W-1:0]       grant;
   logic                    busy;

   modport slave (
      input  empty_P, data_P, almost_full_F,
      output pop_P, push_F, data_F, grant, busy
   );

   modport master (
      output empty_P, data_P, almost_full_F,
      input  pop_P, push_F, data_F, grant, busy
   );
endinterface
`default_nettype wire

// File: rtl/arbitro_wrr_rr_picker.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_picker : first set request at or after start, wrapping mod 4 |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module rr_picker
   import arbitro_pkg::*;
(
   input  logic [NUM_Q-1:0]  i_req,
   input  logic [DEST_W-1:0] i_start,
   output logic              o_found,
   output logic [DEST_W-1:0] o_idx
);

   // Walk from farthest to nearest so the nearest hit is the last write.
   always_comb begin
      logic [DEST_W-1:0] w_idx;
      o_found = 1'b0;
      o_idx   = i_start;
      for (int k = NUM_Q - 1; k >= 0; k--) begin
         w_idx = i_start + DEST_W'(k);
         if (i_req[w_idx]) begin
            o_found = 1'b1;
            o_idx   = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/arbitro_wrr.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arbitro_wrr : weighted round-robin drain of 4 input FIFOs onto  |
// |               4 output FIFOs steered by word[DATA_W-1 -: 2]     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module arbitro_wrr
   import arbitro_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int W0     = 4,
   parameter int W1     = 3,
   parameter int W2     = 2,
   parameter int W3     = 1
)(
   input  logic          clk,
   input  logic          reset,
   arbitro_wrr_if.slave  bus
);

   localparam logic [CRED_W-1:0] c_Q0 = quantum(W0);
   localparam logic [CRED_W-1:0] c_Q1 = quantum(W1);
   localparam logic [CRED_W-1:0] c_Q2 = quantum(W2);
   localparam logic [CRED_W-1:0] c_Q3 = quantum(W3);

   state_t              r_state, w_state_nxt;
   logic [DEST_W-1:0]   r_grant, w_grant_nxt;
   logic [DEST_W-1:0]   r_ptr, w_ptr_nxt;
   logic [CRED_W-1:0]   r_credit, w_credit_nxt;
   logic                w_stall, w_pop, w_done;
   logic                w_found;
   logic [DEST_W-1:0]   w_pick_idx, w_pick_start;
   logic [CRED_W-1:0]   w_pick_cred;

   logic                r_rd_valid;
   logic [DEST_W-1:0]   r_rd_q;
   logic [NUM_Q-1:0]    r_push_F;
   logic [DATA_W-1:0]   r_data_F;
   logic [DATA_W-1:0]   w_lane [NUM_Q];
   logic [DATA_W-1:0]   w_word;

   assign w_stall = |bus.almost_full_F;

   // In SERVE the search starts just past the current queue, so the
   // current one is only re-granted when nothing else is waiting.
   assign w_pick_start = (r_state == SERVE) ? (r_grant + DEST_W'(1)) : r_ptr;

   rr_picker u_picker (
      .i_req   (~bus.empty_P),
      .i_start (w_pick_start),
      .o_found (w_found),
      .o_idx   (w_pick_idx)
   );

   always_comb begin
      case (w_pick_idx)
         2'd0:    w_pick_cred = c_Q0;
         2'd1:    w_pick_cred = c_Q1;
         2'd2:    w_pick_cred = c_Q2;
         default: w_pick_cred = c_Q3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_ptr    <= '0;
         r_credit <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_ptr    <= w_ptr_nxt;
         r_credit <= w_credit_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_ptr_nxt    = r_ptr;
      w_credit_nxt = r_credit;
      w_pop        = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt  = SERVE;
               w_grant_nxt  = w_pick_idx;
               w_credit_nxt = w_pick_cred;
            end
         end
         SERVE: begin
            // A stall freezes the turn entirely; nothing is popped or lost.
            if (!w_stall) begin
               w_pop  = !bus.empty_P[r_grant] && (r_credit != '0) && reset;
               w_done = bus.empty_P[r_grant] || (r_credit == '0) ||
                        (w_pop && (r_credit == CRED_W'(1)));
               if (w_pop)
                  w_credit_nxt = r_credit - CRED_W'(1);
               if (w_done) begin
                  w_ptr_nxt = r_grant + DEST_W'(1);
                  if (w_found) begin
                     w_grant_nxt  = w_pick_idx;
                     w_credit_nxt = w_pick_cred;
                  end else begin
                     w_state_nxt  = IDLE;
                     w_credit_nxt = '0;
                  end
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.pop_P = w_pop ? onehot4(r_grant) : '0;
   assign bus.grant = r_grant;
   assign bus.busy  = (r_state == SERVE);

   for (genvar g = 0; g < NUM_Q; g++) begin : g_lane
      assign w_lane[g] = bus.data_P[g*DATA_W +: DATA_W];
   end

   assign w_word = w_lane[r_rd_q];

   // Pop at N marks the read, data appears at N+1, push is presented at N+2.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_valid <= 1'b0;
         r_rd_q     <= '0;
         r_push_F   <= '0;
         r_data_F   <= '0;
      end else begin
         r_rd_valid <= w_pop;
         r_rd_q     <= r_grant;
         if (r_rd_valid) begin
            r_data_F <= w_word;
            r_push_F <= onehot4(w_word[DATA_W-1 -: DEST_W]);
         end else begin
            r_push_F <= '0;
         end
      end
   end

   assign bus.push_F = r_push_F;
   assign bus.data_F = r_data_F;

endmodule
`default_nettype wire
